// File: rtl/asic_readback_checker.sv
// Purpose : compares ASIC config-chain MISO against MOSI delayed by CHAIN_LEN slots and grades each frame.
// Latency : xor_bit/err_cnt/cmp_cnt 1 CLK after the sampled bit_en; frame_done/pass 1 CLK after sel is seen low.
// Backpr. : none; a passive tap that accepts a bit_en strobe on every CLK.
//
// Ports: CLK/RST_N (async active-low reset); bit_en/sel/mosi/miso serial tap inputs;
//        xor_bit per-bit mismatch; err_cnt/cmp_cnt saturating frame counters;
//        frame_done end-of-frame pulse; pass last frame result; busy in FILL/CHECK.
// Optional: define CHECKER_FIRST_ERR_EN to add first_err_idx/first_err_vld (index of first mismatching slot).
module asic_readback_checker #(
    parameter int CHAIN_LEN = 16,
    parameter int ERR_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             bit_en,
    input  logic             sel,
    input  logic             mosi,
    input  logic             miso,
    output logic             xor_bit,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic             frame_done,
    output logic             pass,
    output logic             busy
`ifdef CHECKER_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Slot index of the last fill bit; the sample taking this slot moves us to CHECK
    // so that a bit_en on the very next CLK is already compared.
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    state_t               state;
    state_t               state_nxt;
    logic                 sel_q;
    logic [CHAIN_LEN-1:0] delay_line;
    logic [CNT_W-1:0]     slot_cnt;

    logic in_frame;
    logic frame_start;
    logic frame_end;
    logic sample;
    logic do_cmp;
    logic mismatch;

    assign in_frame    = (state == ST_FILL) || (state == ST_CHECK);
    assign frame_start = (state == ST_IDLE) && sel && !sel_q;
    // A bit_en in the same cycle sel drops is outside the frame and is ignored.
    assign frame_end   = in_frame && !sel;
    assign sample      = in_frame && sel && bit_en;
    assign do_cmp      = sample && (state == ST_CHECK);
    // Oldest transmitted bit, read before this cycle's shift.
    assign mismatch    = miso ^ delay_line[CHAIN_LEN-1];
    assign busy        = in_frame;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (frame_start) state_nxt = ST_FILL;
            ST_FILL: begin
                if (!sel) begin
                    state_nxt = ST_DONE;
                end else if (sample && (slot_cnt == FILL_LAST)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: if (!sel) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_q         <= 1'b0;
            delay_line    <= '0;
            slot_cnt      <= '0;
            xor_bit       <= 1'b0;
            err_cnt       <= '0;
            cmp_cnt       <= '0;
            frame_done    <= 1'b0;
            pass          <= 1'b0;
`ifdef CHECKER_FIRST_ERR_EN
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
`endif
        end else begin
            sel_q      <= sel;
            frame_done <= frame_end;
            xor_bit    <= do_cmp & mismatch;
            if (frame_start) begin
                delay_line    <= '0;
                slot_cnt      <= '0;
                err_cnt       <= '0;
                cmp_cnt       <= '0;
`ifdef CHECKER_FIRST_ERR_EN
                first_err_idx <= '0;
                first_err_vld <= 1'b0;
`endif
            end else begin
                if (sample) begin
                    delay_line <= {delay_line[CHAIN_LEN-2:0], mosi};
                    if (slot_cnt != '1) slot_cnt <= slot_cnt + CNT_ONE;
                end
                if (do_cmp) begin
                    if (cmp_cnt != '1) cmp_cnt <= cmp_cnt + CNT_ONE;
                    if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + ERR_ONE;
`ifdef CHECKER_FIRST_ERR_EN
                    if (mismatch && !first_err_vld) begin
                        first_err_idx <= slot_cnt;
                        first_err_vld <= 1'b1;
                    end
`endif
                end
                // Counters are stable here: no sample happens while sel is low.
                if (frame_end) pass <= (err_cnt == '0) && (cmp_cnt != '0);
            end
        end
    end

endmodule

// File: tb/tb_asic_readback_checker.sv
// Purpose : scoreboard bench for asic_readback_checker with an 8-bit chain.
// Latency : every output is sampled 1 ns after the CLK rising edge that produced it.
// Backpr. : not applicable; the bench drives the serial tap directly.
module tb_asic_readback_checker;

    localparam int CL      = 8;
    localparam int EW      = 8;
    localparam int CW      = 16;
    localparam int ERR_MAX = (1 << EW) - 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK;
    logic          RST_N;
    logic          bit_en;
    logic          sel;
    logic          mosi;
    logic          miso;
    logic          xor_bit;
    logic [EW-1:0] err_cnt;
    logic [CW-1:0] cmp_cnt;
    logic          frame_done;
    logic          pass;
    logic          busy;
`ifdef CHECKER_FIRST_ERR_EN
    logic [CW-1:0] first_err_idx;
    logic          first_err_vld;
`endif

    asic_readback_checker #(
        .CHAIN_LEN(CL),
        .ERR_W    (EW),
        .CNT_W    (CW)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .bit_en       (bit_en),
        .sel          (sel),
        .mosi         (mosi),
        .miso         (miso),
        .xor_bit      (xor_bit),
        .err_cnt      (err_cnt),
        .cmp_cnt      (cmp_cnt),
        .frame_done   (frame_done),
        .pass         (pass),
        .busy         (busy)
`ifdef CHECKER_FIRST_ERR_EN
        ,
        .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int err;
        int cmp;
        bit pass;
        int first;
    } fexp_t;

    int    total;
    int    bad;
    bit    last_pass;
    int    last_cmp;
    bit    xq[$];
    fexp_t fq[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // n bits in one frame; err_slot flips miso on that compared slot; inv_all flips every
    // compared slot; gaps inserts idle CLKs; fall_bit asserts bit_en with sel falling.
    task automatic run_frame(input int n, input int err_slot, input bit inv_all,
                             input bit gaps, input bit fall_bit);
        bit    mh[$];
        bit    m;
        bit    r;
        bit    e;
        bit    ex;
        int    exp_err;
        int    exp_cmp;
        int    first;
        fexp_t fe;
        exp_err = 0;
        exp_cmp = 0;
        first   = -1;
        sel = 1'b0; bit_en = 1'b0;
        tick();
        sel = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1 || pass !== last_pass || cmp_cnt !== '0 || err_cnt !== '0) begin
            bad++;
            $display("FAIL frame_start: busy=%b pass=%b cmp=%0d err=%0d, want busy=1 pass=%b cmp=0 err=0",
                     busy, pass, cmp_cnt, err_cnt, last_pass);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bit_en = 1'b0;
                xq.push_back(1'b0);
                tick();
                ex = xq.pop_front();
                total++;
                if (xor_bit !== ex) begin
                    bad++;
                    $display("FAIL xor_gap: got %b want %b", xor_bit, ex);
                end
            end
            m = 1'($urandom);
            mh.push_back(m);
            if (i >= CL) begin
                r = mh[i-CL] ^ (inv_all || i == err_slot);
                e = r ^ mh[i-CL];
                if (exp_cmp < CNT_MAX) exp_cmp++;
                if (e && exp_err < ERR_MAX) exp_err++;
                if (e && first < 0) first = i;
            end else begin
                r = 1'($urandom);
                e = 1'b0;
            end
            mosi = m; miso = r; bit_en = 1'b1;
            xq.push_back(e);
            tick();
            ex = xq.pop_front();
            total++;
            if (xor_bit !== ex || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL xor_slot%0d: xor=%b done=%b, want xor=%b done=0", i, xor_bit, frame_done, ex);
            end
        end
        fe.err   = exp_err;
        fe.cmp   = exp_cmp;
        fe.pass  = (exp_err == 0) && (exp_cmp != 0);
        fe.first = first;
        fq.push_back(fe);
        sel = 1'b0; bit_en = fall_bit;
        mosi = 1'($urandom); miso = 1'($urandom);
        tick();
        bit_en = 1'b0;
        fe = fq.pop_front();
        total++;
        if (frame_done !== 1'b1 || pass !== fe.pass || int'(err_cnt) != fe.err ||
            int'(cmp_cnt) != fe.cmp || xor_bit !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_end: done=%b pass=%b err=%0d cmp=%0d xor=%b busy=%b, want 1 %b %0d %0d 0 0",
                     frame_done, pass, err_cnt, cmp_cnt, xor_bit, busy, fe.pass, fe.err, fe.cmp);
        end
`ifdef CHECKER_FIRST_ERR_EN
        total++;
        if (first_err_vld !== (fe.first >= 0) ||
            (fe.first >= 0 && int'(first_err_idx) != fe.first)) begin
            bad++;
            $display("FAIL first_err: vld=%b idx=%0d, want first=%0d", first_err_vld, first_err_idx, fe.first);
        end
`endif
        last_pass = fe.pass;
        last_cmp  = fe.cmp;
        tick();
        total++;
        if (frame_done !== 1'b0 || pass !== last_pass || busy !== 1'b0) begin
            bad++;
            $display("FAIL after_done: done=%b pass=%b busy=%b, want 0 %b 0", frame_done, pass, busy, last_pass);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_en = 1'($urandom); sel = 1'($urandom);
            mosi = 1'($urandom); miso = 1'($urandom);
            tick();
            total++;
            if ({xor_bit, err_cnt, cmp_cnt, frame_done, pass, busy} !== '0) begin
                bad++;
                $display("FAIL reset_hold: xor=%b err=%0d cmp=%0d done=%b pass=%b busy=%b, want all 0",
                         xor_bit, err_cnt, cmp_cnt, frame_done, pass, busy);
            end
        end
        sel = 1'b0; bit_en = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        sel = 1'b0; bit_en = 1'b0;
        tick();
        sel = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            mosi = 1'($urandom); miso = ~mosi; bit_en = 1'b1;
            tick();
        end
        bit_en = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        total++;
        if ({xor_bit, err_cnt, cmp_cnt, frame_done, pass, busy} !== '0) begin
            bad++;
            $display("FAIL async_reset: xor=%b err=%0d cmp=%0d done=%b pass=%b busy=%b, want all 0",
                     xor_bit, err_cnt, cmp_cnt, frame_done, pass, busy);
        end
        sel = 1'b0;
        tick();
        RST_N = 1'b1;
        last_pass = 1'b0;
        last_cmp  = 0;
        tick();
    endtask

    task automatic test_clean();
        run_frame(16, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_error();
        run_frame(16, 11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_short();
        run_frame(16, -1, 1'b0, 1'b1, 1'b0);
        run_frame(5, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        run_frame(300, -1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_edge_bits();
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_en = 1'b1; mosi = 1'($urandom); miso = 1'($urandom);
            tick();
            total++;
            if (int'(cmp_cnt) != last_cmp || busy !== 1'b0 || xor_bit !== 1'b0) begin
                bad++;
                $display("FAIL idle_bit: cmp=%0d busy=%b xor=%b, want cmp=%0d busy=0 xor=0",
                         cmp_cnt, busy, xor_bit, last_cmp);
            end
        end
        bit_en = 1'b0;
        run_frame(12, -1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame(20, -1, 1'b0, 1'b1, 1'b0);
        run_frame(20, 14, 1'b0, 1'b1, 1'b0);
        run_frame(9, -1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; last_pass = 1'b0; last_cmp = 0;
        RST_N = 1'b0; bit_en = 1'b0; sel = 1'b0; mosi = 1'b0; miso = 1'b0;
        test_reset();
        test_clean();
        test_single_error();
        test_clean();
        test_short();
        test_saturation();
        test_edge_bits();
        test_back_to_back();
        test_async_reset();
        test_clean();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asic_readback_checker.md
# asic_readback_checker

Serial readback checker that sits downstream of the ASIC configuration bridge. It taps the bridge's MOSI/SEL stream and the ASIC's MISO return. The ASIC configuration chain is a CHAIN_LEN-bit shift register, so each MISO bit must equal the MOSI bit sent CHAIN_LEN bit-slots earlier in the same frame. The block compares every returned bit against the delayed transmit bit and counts mismatches. At frame end it reports pass/fail, which the top level uses to qualify `end_config`.

## Interface
- CHAIN_LEN, 16: ASIC configuration chain length in bits; valid range 2..1024.
- ERR_W, 8: width of the saturating mismatch counter.
- CNT_W, 16: width of the bit-slot and compared-bit counters.

Ports:
- CLK  in  1  system clock (16 MHz domain).
- RST_N  in  1  reset, asynchronous, active-low.
- bit_en  in  1  one-CLK strobe per serial bit slot, aligned to the serial clock edge on which MISO is valid.
- sel  in  1  frame active (high) for the whole serial frame.
- mosi  in  1  transmitted bit, sampled on bit_en.
- miso  in  1  returned bit, sampled on bit_en.
- xor_bit  out  1  per-bit mismatch result, registered.
- err_cnt  out  ERR_W  mismatches in the current or last frame; saturating.
- cmp_cnt  out  CNT_W  bits compared in the current or last frame; saturating.
- frame_done  out  1  one-CLK pulse at frame end.
- pass  out  1  result of the last completed frame; held until the next frame_done.
- busy  out  1  high while in FILL or CHECK.

## Operation
- States:
  - IDLE -> FILL on sel rising (sel=1 and previous registered sel=0).
  - FILL -> CHECK once slot counter reaches CHAIN_LEN.
  - FILL/CHECK -> DONE on sel falling.
  - DONE -> IDLE unconditionally after 1 cycle.
- Frame start (IDLE->FILL):
  - Clear delay line, slot counter, err_cnt, cmp_cnt and xor_bit.
  - pass keeps its previous value.
- Sampling: on each CLK with bit_en=1 and sel=1 in FILL/CHECK:
  - Shift mosi into a CHAIN_LEN-bit delay line.
  - Increment slot counter (saturates at 2^CNT_W-1).
- FILL: no comparison is made; xor_bit stays 0.
- CHECK, per sampled slot:
  - xor_bit <= miso ^ delay_line[CHAIN_LEN-1], taken before the shift.
  - cmp_cnt +1.
  - err_cnt +1 if mismatch; err_cnt saturates at 2^ERR_W-1 and never wraps.
- xor_bit returns to 0 on any cycle without a sampled compare.
- DONE:
  - frame_done=1.
  - pass <= (err_cnt==0) && (cmp_cnt!=0).
  - A frame ended during FILL therefore gives pass=0.
- Boundary cases:
  - bit_en coincident with sel falling (sel=0 that cycle): the bit is ignored.
  - bit_en while IDLE/DONE: ignored.
  - sel re-rising during DONE: not detected; the next rising edge must follow at least one IDLE cycle.
  - Counter saturation: err_cnt and cmp_cnt hold at their maximum; pass still reflects err_cnt==0.

## Timing
- Reset (asynchronous, RST_N low) sets all outputs to 0 and state to IDLE, regardless of mid-frame state.
- xor_bit, err_cnt and cmp_cnt update 1 CLK after the sampling bit_en edge.
- frame_done and pass update 1 CLK after the first CLK on which sel=0 is sampled while in FILL/CHECK.
- busy is high from the cycle after the sel rising edge until DONE is entered.
- bit_en may be asserted every CLK; no minimum spacing is required.

## Configuration
- Macro: CHECKER_FIRST_ERR_EN.
- Defined:
  - Adds output first_err_idx [CNT_W-1:0], reset 0 and cleared at frame start.
  - Latches the slot index (0-based within the frame) of the first mismatching bit.
  - Adds output first_err_vld [1], set with the latch and cleared at frame start.
- Undefined: neither port exists and no latching logic is built; all other behaviour is identical.

## Test plan
- Reset: hold RST_N=0 with random inputs -> all outputs 0, busy=0. Assert RST_N=0 mid-CHECK -> outputs clear within the same cycle, asynchronously.
- Clean frame, CHAIN_LEN=8: 16 bits, miso equal to mosi delayed by 8 slots -> xor_bit never 1, cmp_cnt=8, err_cnt=0, one frame_done pulse, pass=1.
- Single error: same frame with miso inverted at slot 11 -> xor_bit=1 for exactly one cycle, one CLK after slot 11's bit_en. err_cnt=1, pass=0. With CHECKER_FIRST_ERR_EN: first_err_idx=11, first_err_vld=1.
- Short frame: sel falls after 5 bits -> cmp_cnt=0, err_cnt=0, pass=0, frame_done pulses once.
- Saturation, ERR_W=8: 300-bit frame with miso always inverted -> err_cnt=255 and held, cmp_cnt=292, pass=0.
- Edge case: bit_en in the same cycle sel falls, plus bit_en while IDLE -> neither bit is counted; cmp_cnt equals the number of in-frame CHECK slots only.
